fft_deser4_sync: RTL and testbench

- Receive-side counterpart of the 2-bit lane-cycle counter used by the parallel-4 FFT.
- Accepts a serial sample stream with a start-of-frame strobe and recovers the 4-cycle lane phase.
- Packs every 4 consecutive samples into one 4-lane parallel word for the parallel FFT input.
- Tracks frame position and flags SOF misalignment.

---
 rtl/fft_deser4_sync.sv | 194 +++++++++++++++++++
 tb/tb_fft_deser4_sync.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fft_deser4_sync.sv
// -----------------------------------------------------------------------------
// fft_deser4_sync
//
// Purpose:
//   Receive-side deserializer for the parallel-4 FFT. Takes a serial sample
//   stream with a start-of-frame strobe and recovers the 4-cycle lane phase.
//   Every four accepted samples are packed into one 4-lane word. The block
//   tracks the position within the frame and flags SOF misalignment.
//
// Parameters:
//   NB_DATA : sample width in bits (opaque payload)
//   N       : frame length in samples (multiple of 4, >= 4)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   i_data       serial sample
//   i_valid      i_data valid this cycle
//   i_sof        start of frame, qualified by i_valid
//   o_data0..3   packed group (lane 0 = first sample, lane 3 = last sample)
//   o_valid      1-cycle pulse per completed group
//   o_sof        first group of a frame, coincident with o_valid
//   o_num_ciclo  lane the next accepted sample will occupy
//   o_locked     aligned to the frame
//   o_err        1-cycle pulse on an alignment error
// -----------------------------------------------------------------------------
module fft_deser4_sync #(
    parameter int NB_DATA = 32,
    parameter int N       = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_sof,
    output logic [NB_DATA-1:0] o_data0,
    output logic [NB_DATA-1:0] o_data1,
    output logic [NB_DATA-1:0] o_data2,
    output logic [NB_DATA-1:0] o_data3,
    output logic               o_valid,
    output logic               o_sof,
    output logic [1:0]         o_num_ciclo,
    output logic               o_locked,
    output logic               o_err
);

    localparam int              IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]   IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          phase_q;
    logic [IW-1:0]       idx_q;
    logic                first_q;     // current group started at frame index 0
    logic                valid_q;
    logic                sof_q;
    logic                err_q;

    logic [NB_DATA-1:0]  hold_q [0:2];
    logic [NB_DATA-1:0]  data_q [0:3];

    // Decoded per-sample conditions
    logic          sof_early;    // SOF seen away from frame index 0
    logic          sof_missing;  // frame index 0 reached without SOF
    logic          normal_acc;   // accepted sample continuing the current frame
    logic          restart;      // sample becomes lane 0 of a new frame
    logic          group_done;   // lane 3 accepted, group complete
    logic [2:0]    hold_we;
    logic [1:0]    phase_d;
    logic [IW-1:0] idx_d;

    always_comb begin
        sof_early   = (state_q == LOCKED) && i_valid && i_sof  && (idx_q != '0);
        sof_missing = (state_q == LOCKED) && i_valid && !i_sof && (idx_q == '0);
        normal_acc  = (state_q == LOCKED) && i_valid && !sof_early && !sof_missing;
        restart     = ((state_q == UNLOCKED) && i_valid && i_sof) || sof_early;
        group_done  = normal_acc && (phase_q == 2'd3);
        phase_d     = phase_q + 2'd1;
        idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end

    // Holding registers for lanes 0..2; lane 3 goes straight to the output.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hold
            if (gi == 0) begin : g_lane0
                assign hold_we[gi] = restart || (normal_acc && (phase_q == 2'd0));
            end else begin : g_laneN
                assign hold_we[gi] = normal_acc && (phase_q == 2'(gi));
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q[gi] <= '0;
                end else if (hold_we[gi]) begin
                    hold_q[gi] <= i_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q[gi] <= '0;
                end else if (group_done) begin
                    data_q[gi] <= hold_q[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[3] <= '0;
        end else if (group_done) begin
            data_q[3] <= i_data;
        end
    end

    // Frame-alignment FSM with its counters and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
            phase_q <= 2'd0;
            idx_q   <= '0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            err_q   <= 1'b0;
            if (i_valid) begin
                case (state_q)
                    UNLOCKED: begin
                        // Samples without SOF are dropped while unlocked.
                        if (i_sof) begin
                            state_q <= LOCKED;
                            phase_q <= 2'd1;
                            idx_q   <= IDX_ONE;
                            first_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (sof_early) begin
                            // Partial group is abandoned; this sample opens a new frame.
                            err_q   <= 1'b1;
                            phase_q <= 2'd1;
                            idx_q   <= IDX_ONE;
                            first_q <= 1'b1;
                        end else if (sof_missing) begin
                            err_q   <= 1'b1;
                            state_q <= UNLOCKED;
                            phase_q <= 2'd0;
                            idx_q   <= '0;
                        end else begin
                            // Index is a multiple of 4 whenever phase is 0, so the
                            // group's frame-start flag is captured on lane 0.
                            if (phase_q == 2'd0) begin
                                first_q <= (idx_q == '0);
                            end
                            if (phase_q == 2'd3) begin
                                valid_q <= 1'b1;
                                sof_q   <= first_q;
                            end
                            phase_q <= phase_d;
                            idx_q   <= idx_d;
                        end
                    end
                    default: begin
                        state_q <= UNLOCKED;
                        phase_q <= 2'd0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_data0     = data_q[0];
    assign o_data1     = data_q[1];
    assign o_data2     = data_q[2];
    assign o_data3     = data_q[3];
    assign o_valid     = valid_q;
    assign o_sof       = sof_q;
    assign o_num_ciclo = phase_q;
    assign o_locked    = (state_q == LOCKED);
    assign o_err       = err_q;

endmodule

// File: tb/tb_fft_deser4_sync.sv
// -----------------------------------------------------------------------------
// tb_fft_deser4_sync
//
// Directed bench for fft_deser4_sync (NB_DATA=32, N=128). A behavioural model
// predicts the registered outputs after every clock; completed groups are
// pushed to a scoreboard queue and popped when the DUT raises o_valid.
// -----------------------------------------------------------------------------
module tb_fft_deser4_sync;

    localparam int NB = 32;
    localparam int NF = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] i_data;
    logic          i_valid;
    logic          i_sof;
    logic [NB-1:0] o_data0, o_data1, o_data2, o_data3;
    logic          o_valid, o_sof, o_locked, o_err;
    logic [1:0]    o_num_ciclo;

    fft_deser4_sync #(.NB_DATA(NB), .N(NF)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .o_data0     (o_data0),
        .o_data1     (o_data1),
        .o_data2     (o_data2),
        .o_data3     (o_data3),
        .o_valid     (o_valid),
        .o_sof       (o_sof),
        .o_num_ciclo (o_num_ciclo),
        .o_locked    (o_locked),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] d0;
        logic [NB-1:0] d1;
        logic [NB-1:0] d2;
        logic [NB-1:0] d3;
        logic          sof;
    } grp_t;

    grp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    bit armed    = 0;

    // Model state: predicted DUT outputs after the most recent clock edge
    bit            m_locked;
    int            m_phase;
    int            m_idx;
    bit            m_first;
    logic [NB-1:0] m_hold [0:2];
    logic [NB-1:0] m_data [0:3];
    bit            m_valid, m_osof, m_err;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        grp_t g;
        chk("o_valid",     160'(o_valid),     160'(m_valid));
        chk("o_sof",       160'(o_sof),       160'(m_osof));
        chk("o_err",       160'(o_err),       160'(m_err));
        chk("o_locked",    160'(o_locked),    160'(m_locked));
        chk("o_num_ciclo", 160'(o_num_ciclo), 160'(m_phase));
        chk("o_data_hold", 160'({o_data0, o_data1, o_data2, o_data3}),
            160'({m_data[0], m_data[1], m_data[2], m_data[3]}));
        if (o_valid === 1'b1) begin
            chk("sb_nonempty", 160'(sb.size() != 0), 160'(1));
            if (sb.size() != 0) begin
                g = sb.pop_front();
                $display("group: d=%0d,%0d,%0d,%0d sof=%0b err=%0b (exp %0d,%0d,%0d,%0d sof=%0b)",
                         o_data0, o_data1, o_data2, o_data3, o_sof, o_err,
                         g.d0, g.d1, g.d2, g.d3, g.sof);
                chk("sb_data", 160'({o_data0, o_data1, o_data2, o_data3}),
                    160'({g.d0, g.d1, g.d2, g.d3}));
                chk("sb_sof", 160'(o_sof), 160'(g.sof));
            end
        end
    endtask

    task automatic model_advance(input bit r, input bit v, input bit s, input logic [NB-1:0] d);
        grp_t g;
        m_valid = 0;
        m_osof  = 0;
        m_err   = 0;
        if (r) begin
            m_locked = 0; m_phase = 0; m_idx = 0; m_first = 0;
            for (int k = 0; k < 3; k++) m_hold[k] = '0;
            for (int k = 0; k < 4; k++) m_data[k] = '0;
            sb.delete();
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_hold[0] = d; m_phase = 1; m_idx = 1; m_first = 1; m_locked = 1;
                end
            end else if (s && m_idx != 0) begin
                m_err = 1; m_hold[0] = d; m_phase = 1; m_idx = 1; m_first = 1;
            end else if (!s && m_idx == 0) begin
                m_err = 1; m_locked = 0; m_phase = 0; m_idx = 0;
            end else begin
                if (m_phase == 0) m_first = (m_idx == 0);
                if (m_phase < 3) begin
                    m_hold[m_phase] = d;
                end else begin
                    g.d0 = m_hold[0]; g.d1 = m_hold[1]; g.d2 = m_hold[2]; g.d3 = d;
                    g.sof = m_first;
                    sb.push_back(g);
                    m_data[0] = m_hold[0]; m_data[1] = m_hold[1];
                    m_data[2] = m_hold[2]; m_data[3] = d;
                    m_valid = 1; m_osof = m_first;
                end
                m_phase = (m_phase + 1) % 4;
                m_idx   = (m_idx + 1) % NF;
            end
        end
    endtask

    // One clock: check the outputs of the previous edge, then drive new inputs.
    task automatic step(input bit r, input bit v, input bit s, input logic [NB-1:0] d);
        @(negedge clk);
        if (armed) check_outputs();
        rst = r; i_valid = v; i_sof = s; i_data = d;
        model_advance(r, v, s, d);
        if (r) armed = 1;
    endtask

    task automatic send(input int base, input int n, input int sof_at, input bit gaps);
        for (int k = 0; k < n; k++) begin
            while (gaps && ($urandom_range(0, 1) == 1)) step(0, 0, 0, '0);
            step(0, 1, (k == sof_at), NB'(base + k));
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;

        // Reset
        step(1, 0, 0, '0);
        step(1, 1, 1, 32'hDEAD);
        step(0, 0, 0, '0);

        // Gap-free frame 0..127
        send(0, NF, 0, 0);
        step(0, 0, 0, '0);

        // Missing SOF at next frame start, 9 dropped samples, then two gapped frames
        send(1000, 10, -1, 0);
        send(2000, NF, 0, 1);
        send(3000, NF, 0, 1);

        // Premature SOF at index 6, new frame completes, then missing SOF
        send(4000, 6, 0, 0);
        send(5000, NF, 0, 0);
        send(6000, 1, -1, 0);
        step(0, 0, 0, '0);
        send(6100, 3, -1, 1);

        // Reset after 2 samples of a group; relock only on the next SOF
        send(7000, 2, 0, 0);
        step(1, 1, 1, 32'h7777);
        send(8000, 4, -1, 0);
        send(9000, 8, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, '0);

        chk("sb_drained", 160'(sb.size()), 160'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
